rob_wb_collector: RTL and testbench
===================================

# rob_wb_collector

Writeback collector at the consumer end of the ALU result interface. It captures each ALU result into a 16-entry slot array indexed by destination ROB tag, and holds it for the commit delay the ALU reported. Ready results then go to the ROB, one per cycle, through a round-robin arbiter. It sits between the ALU output registers and the ROB completion port.

## Interface
- No parameters: entry count 16 (4-bit ROB tag), data 32 bits, FID 8 bits, delay 4 bits; all fixed.
- clk  in  1  clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- i_valid  in  1  ALU result valid
- i_dst_rob  in  4  destination ROB tag / slot index
- i_fid  in  8  FID carried with the result
- i_result  in  32  result value
- i_cmtdelay  in  4  extra cycles to hold before the result is eligible
- i_flush  in  1  pipeline flush; kills all held and incoming results
- o_wb_valid  out  1  completion valid to ROB (registered)
- o_wb_rob  out  4  completing ROB tag (registered)
- o_wb_fid  out  8  completing FID (registered)
- o_wb_value  out  32  completing value (registered)
- o_busy  out  16  per-slot occupancy vector (registered state)
- o_overwrite_err  out  1  sticky: a write hit an occupied slot that did not retire the same cycle

## Operation
- Per-slot state: vld, cnt[3:0], fid[7:0], val[31:0].
- Write: i_valid && !i_flush sets slot[i_dst_rob] as follows: vld=1, cnt=i_cmtdelay, fid/val loaded.
- Countdown: every cycle, each vld slot with cnt!=0 decrements by 1. cnt saturates at 0 and never wraps.
- Eligible: vld && cnt==0, evaluated on registered state.
- Arbiter: scan from rr_ptr upward, wrapping 15→0. The first eligible slot is granted. On a grant:
  - slot vld is cleared.
  - o_wb_* regs are loaded from the slot, o_wb_valid=1.
  - rr_ptr = grant+1 mod 16.
- No grant: o_wb_valid=0 and rr_ptr holds. o_wb_rob/fid/value hold their last values (don't-care when invalid).
- Write and grant to the same slot in the same cycle: the old contents are emitted and the new write is installed. No error is raised.
- Write to a vld slot that is not granted that cycle: the new data replaces the old, so the old result is lost. o_overwrite_err is set to 1 and stays set until reset.
- Flush: i_flush=1 clears all slot vld bits at the edge. o_wb_valid=0 the following cycle. Any same-cycle i_valid is dropped, and any same-cycle grant is suppressed. rr_ptr and o_overwrite_err are unaffected.
- o_busy[i] = slot[i].vld.

## Timing
- Reset values (async assert): every vld=0 and cnt=0, rr_ptr=0, o_wb_valid=0, o_wb_rob=0, o_wb_fid=0, o_wb_value=0, o_busy=0, o_overwrite_err=0.
- Reset release is synchronous to clk. The first write is accepted on the first edge with resetn=1.
- Uncontended latency: i_valid in cycle 0 gives o_wb_valid in cycle 2+i_cmtdelay (slot eligible in cycle 1+i_cmtdelay, output registered one edge later).
- Throughput: one write and one completion per cycle, sustained.
- Contended slots wait. Their cnt stays 0 while waiting.
- No backpressure: the ROB must accept o_wb_valid every cycle.

## Test plan
- Single result, zero delay: reset, then i_valid with rob=5, fid=0x21, result=0x12345678, cmtdelay=0 in cycle 0 → o_wb_valid=1 in cycle 2 only, with rob=5, fid=0x21, value=0x12345678; o_busy=0x0020 in cycle 1, 0x0000 in cycle 2.
- Delay: rob=3, cmtdelay=3 in cycle 0 → o_wb_valid in cycle 5 only, o_busy[3]=1 in cycles 1–4.
- Arbitration: rob=2 and rob=9 written (cmtdelay 1 and 0) so both become eligible in cycle 2, rr_ptr=0 → rob 2 completes in cycle 3, rob 9 in cycle 4; next lone eligible rob 1 completes only after the scan wraps from rr_ptr=10.
- Overwrite: rob=4 cmtdelay=15 val=0xAAAA0000, then rob=4 cmtdelay=0 val=0x5555FFFF two cycles later → exactly one completion, rob 4 value 0x5555FFFF; o_overwrite_err=1. Also drive a same-cycle write and grant on one slot → both values emitted in order, err stays 0 after a fresh reset.
- Flush: three slots pending, then i_flush=1 together with i_valid on rob=7 → o_busy=0 next cycle, no o_wb_valid afterwards, rob 7 never completes.
- Reset mid-operation: assert resetn=0 asynchronously while o_wb_valid=1 and slots are busy → outputs go to reset values immediately without a clock edge; after release, no stale completion appears.

Source files
------------

// File: rtl/rob_wb_collector.sv
// Purpose: capture ALU results into 16 ROB-tag-indexed slots, hold each for its commit delay, then retire them to the ROB.
// Latency: i_valid in cycle 0 -> o_wb_valid in cycle 2+i_cmtdelay when uncontended; one write and one completion per cycle.
// Backpressure: none; the ROB accepts every o_wb_valid, and contended eligible slots wait with cnt held at 0.
module rob_wb_collector (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_valid,
    input  logic [3:0]  i_dst_rob,
    input  logic [7:0]  i_fid,
    input  logic [31:0] i_result,
    input  logic [3:0]  i_cmtdelay,
    input  logic        i_flush,
    output logic        o_wb_valid,
    output logic [3:0]  o_wb_rob,
    output logic [7:0]  o_wb_fid,
    output logic [31:0] o_wb_value,
    output logic [15:0] o_busy,
    output logic        o_overwrite_err
);

    // Slot array, indexed by destination ROB tag.
    logic [15:0] vld;
    logic [3:0]  cnt     [16];
    logic [7:0]  fid_q   [16];
    logic [31:0] val_q   [16];

    logic [3:0]  rr_ptr;
    logic [15:0] elig;
    logic        grant_vld;
    logic [3:0]  grant_idx;
    logic        grant_fire;
    logic        wr;

    // A slot may retire once its countdown has drained; uses registered state only.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            elig[i] = vld[i] && (cnt[i] == 4'd0);
        end
    end

    // Round-robin pick: first eligible slot at or above rr_ptr, wrapping 15 -> 0.
    always_comb begin
        logic [3:0] idx;
        idx       = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < 16; k++) begin
            idx = rr_ptr + 4'(k);
            if (!grant_vld && elig[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Flush kills both the incoming write and any retirement this cycle.
    assign grant_fire = grant_vld && !i_flush;
    assign wr         = i_valid && !i_flush;

    // Slot update: a write wins over a same-cycle grant so the new result is installed
    // while the old one is emitted; otherwise grant/flush clear and the counter drains.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld <= '0;
            for (int i = 0; i < 16; i++) begin
                cnt[i]   <= '0;
                fid_q[i] <= '0;
                val_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (wr && (i_dst_rob == 4'(i))) begin
                    vld[i]   <= 1'b1;
                    cnt[i]   <= i_cmtdelay;
                    fid_q[i] <= i_fid;
                    val_q[i] <= i_result;
                end else begin
                    if (i_flush || (grant_fire && (grant_idx == 4'(i)))) begin
                        vld[i] <= 1'b0;
                    end
                    if (vld[i] && (cnt[i] != 4'd0)) begin
                        cnt[i] <= cnt[i] - 4'd1;
                    end
                end
            end
        end
    end

    // Completion register and round-robin pointer advance on each retirement.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_wb_valid <= 1'b0;
            o_wb_rob   <= '0;
            o_wb_fid   <= '0;
            o_wb_value <= '0;
            rr_ptr     <= '0;
        end else if (grant_fire) begin
            o_wb_valid <= 1'b1;
            o_wb_rob   <= grant_idx;
            o_wb_fid   <= fid_q[grant_idx];
            o_wb_value <= val_q[grant_idx];
            rr_ptr     <= grant_idx + 4'd1;
        end else begin
            o_wb_valid <= 1'b0;
        end
    end

    // Sticky error: a write landed on a live slot that was not retiring this cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_overwrite_err <= 1'b0;
        end else if (wr && vld[i_dst_rob] && !(grant_fire && (grant_idx == i_dst_rob))) begin
            o_overwrite_err <= 1'b1;
        end
    end

    assign o_busy = vld;

endmodule

// File: tb/tb_rob_wb_collector.sv
// Purpose: directed scoreboard bench for rob_wb_collector.
// Latency: expected completions carry the cycle they must appear in.
// Backpressure: none; the monitor checks every o_wb_valid cycle.
module tb_rob_wb_collector;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_valid = 1'b0;
    logic [3:0]  i_dst_rob = '0;
    logic [7:0]  i_fid = '0;
    logic [31:0] i_result = '0;
    logic [3:0]  i_cmtdelay = '0;
    logic        i_flush = 1'b0;
    logic        o_wb_valid;
    logic [3:0]  o_wb_rob;
    logic [7:0]  o_wb_fid;
    logic [31:0] o_wb_value;
    logic [15:0] o_busy;
    logic        o_overwrite_err;

    rob_wb_collector dut (
        .clk             (clk),
        .resetn          (resetn),
        .i_valid         (i_valid),
        .i_dst_rob       (i_dst_rob),
        .i_fid           (i_fid),
        .i_result        (i_result),
        .i_cmtdelay      (i_cmtdelay),
        .i_flush         (i_flush),
        .o_wb_valid      (o_wb_valid),
        .o_wb_rob        (o_wb_rob),
        .o_wb_fid        (o_wb_fid),
        .o_wb_value      (o_wb_value),
        .o_busy          (o_busy),
        .o_overwrite_err (o_overwrite_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rob;
        logic [7:0]  fid;
        logic [31:0] val;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Cycle n is the interval after the n-th rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every completion must match the oldest expectation, in the expected cycle.
    always @(negedge clk) begin
        if (resetn && o_wb_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected cyc=%0d got rob=%0d fid=%h val=%h required none",
                         cyc, o_wb_rob, o_wb_fid, o_wb_value);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (o_wb_rob !== e.rob || o_wb_fid !== e.fid || o_wb_value !== e.val || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL wb_data got rob=%0d fid=%h val=%h cyc=%0d required rob=%0d fid=%h val=%h cyc=%0d",
                             o_wb_rob, o_wb_fid, o_wb_value, cyc, e.rob, e.fid, e.val, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic expect_wb(input logic [3:0] rob, input logic [7:0] fid, input logic [31:0] val, input int c);
        exp_t e;
        e.rob = rob; e.fid = fid; e.val = val; e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of stimulus, applied at the falling edge.
    task automatic drive(input logic v, input logic [3:0] rob, input logic [7:0] fid,
                         input logic [31:0] val, input logic [3:0] d, input logic fl);
        @(negedge clk);
        i_valid = v; i_dst_rob = rob; i_fid = fid; i_result = val; i_cmtdelay = d; i_flush = fl;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 4'd0, 8'd0, 32'd0, 4'd0, 1'b0);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        #2;
        resetn = 1'b0;
        i_valid = 1'b0; i_flush = 1'b0;
        #1;
        chk("reset_valid", 64'(o_wb_valid), 64'd0);
        chk("reset_busy",  64'(o_busy), 64'd0);
        chk("reset_err",   64'(o_overwrite_err), 64'd0);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    int c0;

    initial begin
        // Initial reset, checking every output's reset value.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(o_wb_valid), 64'd0);
        chk("rst_rob",   64'(o_wb_rob), 64'd0);
        chk("rst_fid",   64'(o_wb_fid), 64'd0);
        chk("rst_value", 64'(o_wb_value), 64'd0);
        chk("rst_busy",  64'(o_busy), 64'd0);
        chk("rst_err",   64'(o_overwrite_err), 64'd0);
        resetn = 1'b1;

        // Single result, zero delay.
        drive(1'b1, 4'd5, 8'h21, 32'h12345678, 4'd0, 1'b0);
        c0 = cyc;
        expect_wb(4'd5, 8'h21, 32'h12345678, c0 + 2);
        idle(1);
        chk("t1_busy_c1", 64'(o_busy), 64'h0020);
        idle(1);
        chk("t1_busy_c2", 64'(o_busy), 64'h0000);
        idle(3);

        // Delay of 3: busy in cycles 1..4, completion in cycle 5.
        drive(1'b1, 4'd3, 8'h33, 32'hDEAD0003, 4'd3, 1'b0);
        c0 = cyc;
        expect_wb(4'd3, 8'h33, 32'hDEAD0003, c0 + 5);
        for (int k = 1; k <= 5; k++) begin
            idle(1);
            chk($sformatf("t2_busy3_c%0d", k), 64'(o_busy[3]), (k <= 4) ? 64'd1 : 64'd0);
        end
        idle(3);

        // Arbitration: rr_ptr=0 from the two earlier grants? rr_ptr is 4 now, so 9 then 2
        // would be wrong order; fresh reset puts rr_ptr at 0.
        hard_reset();
        drive(1'b1, 4'd2, 8'h02, 32'h00000002, 4'd1, 1'b0);
        c0 = cyc;
        drive(1'b1, 4'd9, 8'h09, 32'h00000009, 4'd0, 1'b0);
        expect_wb(4'd2, 8'h02, 32'h00000002, c0 + 3);
        expect_wb(4'd9, 8'h09, 32'h00000009, c0 + 4);
        idle(2);
        // rr_ptr is 10 after rob 9; rob 1 and rob 12 become eligible together.
        drive(1'b1, 4'd1, 8'h01, 32'h00000001, 4'd1, 1'b0);
        drive(1'b1, 4'd12, 8'h0C, 32'h0000000C, 4'd0, 1'b0);
        expect_wb(4'd12, 8'h0C, 32'h0000000C, c0 + 7);
        expect_wb(4'd1, 8'h01, 32'h00000001, c0 + 8);
        idle(6);
        chk("t3_err", 64'(o_overwrite_err), 64'd0);

        // Overwrite of a live, non-retiring slot.
        drive(1'b1, 4'd4, 8'h44, 32'hAAAA0000, 4'd15, 1'b0);
        c0 = cyc;
        idle(1);
        drive(1'b1, 4'd4, 8'h45, 32'h5555FFFF, 4'd0, 1'b0);
        expect_wb(4'd4, 8'h45, 32'h5555FFFF, c0 + 4);
        idle(1);
        chk("t4_err_set", 64'(o_overwrite_err), 64'd1);
        idle(20);
        chk("t4_err_sticky", 64'(o_overwrite_err), 64'd1);
        chk("t4_busy", 64'(o_busy), 64'd0);

        // Same-cycle write and grant on one slot: both emitted, no error.
        hard_reset();
        drive(1'b1, 4'd6, 8'h61, 32'h11111111, 4'd0, 1'b0);
        c0 = cyc;
        drive(1'b1, 4'd6, 8'h62, 32'h22222222, 4'd0, 1'b0);
        expect_wb(4'd6, 8'h61, 32'h11111111, c0 + 2);
        expect_wb(4'd6, 8'h62, 32'h22222222, c0 + 3);
        idle(4);
        chk("t4b_err", 64'(o_overwrite_err), 64'd0);

        // Flush with three pending slots and a same-cycle write to rob 7.
        drive(1'b1, 4'd10, 8'hA0, 32'h0000000A, 4'd5, 1'b0);
        drive(1'b1, 4'd11, 8'hB0, 32'h0000000B, 4'd5, 1'b0);
        drive(1'b1, 4'd12, 8'hC0, 32'h0000000C, 4'd5, 1'b0);
        idle(1);
        chk("t5_busy_pre", 64'(o_busy), 64'h1C00);
        drive(1'b1, 4'd7, 8'h70, 32'h00000007, 4'd0, 1'b0);
        i_flush = 1'b1;
        idle(1);
        chk("t5_busy_post", 64'(o_busy), 64'h0000);
        chk("t5_valid_post", 64'(o_wb_valid), 64'd0);
        idle(20);
        chk("t5_err", 64'(o_overwrite_err), 64'd0);

        // Asynchronous reset while a completion is on the output and a slot is busy.
        drive(1'b1, 4'd0, 8'hF0, 32'hCAFEF00D, 4'd0, 1'b0);
        c0 = cyc;
        expect_wb(4'd0, 8'hF0, 32'hCAFEF00D, c0 + 2);
        drive(1'b1, 4'd5, 8'hF5, 32'hBEEF0005, 4'd9, 1'b0);
        idle(1);
        chk("t6_valid_pre", 64'(o_wb_valid), 64'd1);
        chk("t6_busy_pre",  64'(o_busy), 64'h0020);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_valid_async", 64'(o_wb_valid), 64'd0);
        chk("t6_rob_async",   64'(o_wb_rob), 64'd0);
        chk("t6_fid_async",   64'(o_wb_fid), 64'd0);
        chk("t6_value_async", 64'(o_wb_value), 64'd0);
        chk("t6_busy_async",  64'(o_busy), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        idle(16);
        chk("t6_busy_after", 64'(o_busy), 64'd0);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
